// File: rtl/spi_responder_regfile.sv
// SPI mode-0 responder with a 2**ADDR_W x 8 register file (CTRL_CLK domain).
// Ports: CTRL_CLK, RST (sync, active-high), CS/SCLK/SDI in, SDO, WR_VALID/WR_ADDR/WR_DATA, BUSY, FRAME_ERR out.
// Macro SPI_RESP_READBACK_EN enables read data on SDO; undefined, reads are accepted and SDO stays 0.
module spi_responder_regfile #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              CTRL_CLK,
  input  logic              RST,
  input  logic              CS,
  input  logic              SCLK,
  input  logic              SDI,
  output logic              SDO,
  output logic              WR_VALID,
  output logic [ADDR_W-1:0] WR_ADDR,
  output logic [DATA_W-1:0] WR_DATA,
  output logic              BUSY,
  output logic              FRAME_ERR
);

  localparam int NREG = 2**ADDR_W;
  localparam int CW   = $clog2(DATA_W);

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

  state_t            state;
  logic [2:0]        cs_s;
  logic [2:0]        sclk_s;
  logic [1:0]        sdi_s;
  logic [CW-1:0]     bit_cnt;
  logic [DATA_W-2:0] shift_in;
  logic [ADDR_W-1:0] ptr;
  logic              rd;
  logic [DATA_W-1:0] regs [NREG];

  logic              cs_fall;
  logic              cs_rise;
  logic              sclk_rise;
  logic [DATA_W-1:0] nbyte;
  logic [ADDR_W-1:0] ptr_nxt;

  // stage 1 is the synchronized level, stage 2 the delayed copy for edges
  assign cs_fall   = cs_s[2] & ~cs_s[1];
  assign cs_rise   = ~cs_s[2] & cs_s[1];
  assign sclk_rise = ~sclk_s[2] & sclk_s[1] & ~cs_s[1];
  assign nbyte     = {shift_in, sdi_s[1]};
  assign ptr_nxt   = ptr + 1'b1;

`ifdef SPI_RESP_READBACK_EN
  logic              sclk_fall;
  logic [DATA_W-1:0] shift_out;

  assign sclk_fall = sclk_s[2] & ~sclk_s[1] & ~cs_s[1];
  assign SDO       = shift_out[DATA_W-1];
`else
  assign SDO = 1'b0;
`endif

  always_ff @(posedge CTRL_CLK) begin
    if (RST) begin
      state     <= IDLE;
      cs_s      <= '0;
      sclk_s    <= '0;
      sdi_s     <= '0;
      bit_cnt   <= '0;
      shift_in  <= '0;
      ptr       <= '0;
      rd        <= 1'b0;
      WR_VALID  <= 1'b0;
      WR_ADDR   <= '0;
      WR_DATA   <= '0;
      BUSY      <= 1'b0;
      FRAME_ERR <= 1'b0;
`ifdef SPI_RESP_READBACK_EN
      shift_out <= '0;
`endif
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      cs_s      <= {cs_s[1:0], CS};
      sclk_s    <= {sclk_s[1:0], SCLK};
      sdi_s     <= {sdi_s[0], SDI};
      WR_VALID  <= 1'b0;
      FRAME_ERR <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cs_fall) begin
            state    <= CMD;
            BUSY     <= 1'b1;
            bit_cnt  <= '0;
            shift_in <= '0;
`ifdef SPI_RESP_READBACK_EN
            shift_out <= '0;
`endif
          end
        end
        CMD, DATA: begin
          if (cs_rise) begin
            // a partial byte is simply dropped
            state     <= IDLE;
            BUSY      <= 1'b0;
            FRAME_ERR <= (bit_cnt != '0);
            bit_cnt   <= '0;
`ifdef SPI_RESP_READBACK_EN
            shift_out <= '0;
`endif
          end else if (sclk_rise) begin
            shift_in <= nbyte[DATA_W-2:0];
            bit_cnt  <= bit_cnt + 1'b1;
            if (bit_cnt == CW'(DATA_W - 1)) begin
              if (state == CMD) begin
                state <= DATA;
                rd    <= nbyte[DATA_W-1];
                ptr   <= nbyte[ADDR_W-1:0];
`ifdef SPI_RESP_READBACK_EN
                shift_out <= nbyte[DATA_W-1] ?
                             regs[nbyte[ADDR_W-1:0]] : '0;
`endif
              end else begin
                ptr <= ptr_nxt;
                if (!rd) begin
                  regs[ptr] <= nbyte;
                  WR_VALID  <= 1'b1;
                  WR_ADDR   <= ptr;
                  WR_DATA   <= nbyte;
                end
`ifdef SPI_RESP_READBACK_EN
                shift_out <= rd ? regs[ptr_nxt] : '0;
`endif
              end
            end
          end
`ifdef SPI_RESP_READBACK_EN
          // the fall right after a byte completes must keep the fresh MSB
          else if (sclk_fall && bit_cnt != '0) begin
            shift_out <= {shift_out[DATA_W-2:0], 1'b0};
          end
`endif
        end
        default: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_responder_regfile.sv
// Self-checking bench for spi_responder_regfile.
// Table-driven write frames, scoreboarded WR_VALID, plus read/abort/reset sequences.
module tb_spi_responder_regfile;

  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cs = 1'b1;
  logic              sclk = 1'b0;
  logic              sdi = 1'b0;
  logic              sdo;
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              busy;
  logic              frame_err;

  int tests = 0;
  int fails = 0;
  int wr_cnt = 0;
  int ferr_cnt = 0;
  logic [ADDR_W+7:0] sb [$];
  logic [ADDR_W+7:0] sb_exp;

  spi_responder_regfile #(.ADDR_W(ADDR_W), .DATA_W(8)) dut (
    .CTRL_CLK (clk),
    .RST      (rst),
    .CS       (cs),
    .SCLK     (sclk),
    .SDI      (sdi),
    .SDO      (sdo),
    .WR_VALID (wr_valid),
    .WR_ADDR  (wr_addr),
    .WR_DATA  (wr_data),
    .BUSY     (busy),
    .FRAME_ERR(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_valid) begin
      wr_cnt++;
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_wr got addr=%0d data=%h, none expected",
                 wr_addr, wr_data);
      end else begin
        sb_exp = sb.pop_front();
        if ({wr_addr, wr_data} !== sb_exp) begin
          fails++;
          $display("FAIL wr_scoreboard got %0d/%h expected %0d/%h",
                   wr_addr, wr_data, sb_exp[ADDR_W+7:8], sb_exp[7:0]);
        end
      end
    end
    if (frame_err) ferr_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic xbit(input logic b, output logic r);
    sdi = b;
    #50;
    r = sdo;
    sclk = 1'b1;
    #50;
    sclk = 1'b0;
  endtask

  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) xbit(tx[i], rx[i]);
  endtask

  task automatic cs_lo();
    cs = 1'b0;
    #100;
  endtask

  task automatic cs_hi();
    #100;
    cs = 1'b1;
    #200;
  endtask

  typedef struct {
    logic [7:0]             cmd;
    int                     n;
    logic [2:0][7:0]        d;
    logic [2:0][ADDR_W-1:0] a;
  } vec_t;

  vec_t tbl [4];

  logic [7:0] rx;
  logic [7:0] rx_or;
  logic [7:0] r0;
  logic [7:0] r1;
  logic [7:0] r2;
  logic       rb;
  logic [7:0] exp_a5;
  logic [7:0] exp_11;
  logic [7:0] exp_22;
  int         wr0;
  int         fe0;

  initial begin
    tbl[0].cmd = 8'h03; tbl[0].n = 1;
    tbl[0].d = {8'h00, 8'h00, 8'hA5}; tbl[0].a = {4'd0, 4'd0, 4'd3};
    tbl[1].cmd = 8'h0E; tbl[1].n = 3;
    tbl[1].d = {8'h33, 8'h22, 8'h11}; tbl[1].a = {4'd0, 4'd15, 4'd14};
    tbl[2].cmd = 8'h79; tbl[2].n = 1;
    tbl[2].d = {8'h00, 8'h00, 8'h5A}; tbl[2].a = {4'd0, 4'd0, 4'd9};
    tbl[3].cmd = 8'h07; tbl[3].n = 2;
    tbl[3].d = {8'h00, 8'h3C, 8'hC3}; tbl[3].a = {4'd0, 4'd8, 4'd7};

`ifdef SPI_RESP_READBACK_EN
    exp_a5 = 8'hA5; exp_11 = 8'h11; exp_22 = 8'h22;
`else
    exp_a5 = 8'h00; exp_11 = 8'h00; exp_22 = 8'h00;
`endif

    repeat (5) @(posedge clk);
    #1;
    chk("rst_sdo", {31'd0, sdo}, 0);
    chk("rst_wr_valid", {31'd0, wr_valid}, 0);
    chk("rst_frame_err", {31'd0, frame_err}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_wr_addr", {28'd0, wr_addr}, 0);
    chk("rst_wr_data", {24'd0, wr_data}, 0);
    rst = 1'b0;
    #200;

    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < tbl[i].n; k++) sb.push_back({tbl[i].a[k], tbl[i].d[k]});
      cs_lo();
      chk($sformatf("busy_v%0d", i), {31'd0, busy}, 1);
      xfer(tbl[i].cmd, rx);
      rx_or = rx;
      for (int k = 0; k < tbl[i].n; k++) begin
        xfer(tbl[i].d[k], rx);
        rx_or |= rx;
      end
      cs_hi();
      chk($sformatf("wr_sdo_v%0d", i), {24'd0, rx_or}, 0);
      chk($sformatf("pending_v%0d", i), sb.size(), 0);
      chk($sformatf("idle_v%0d", i), {31'd0, busy}, 0);
      for (int k = 0; k < tbl[i].n; k++)
        chk($sformatf("reg_v%0d_%0d", i, k),
            {24'd0, dut.regs[tbl[i].a[k]]}, {24'd0, tbl[i].d[k]});
    end

    wr0 = wr_cnt;
    cs_lo();
    xfer(8'h83, r0);
    xfer(8'h00, r1);
    cs_hi();
    chk("rd_cmd_sdo", {24'd0, r0}, 0);
    chk("rd_reg3", {24'd0, r1}, {24'd0, exp_a5});
    cs_lo();
    xfer(8'h8E, r0);
    xfer(8'h00, r1);
    xfer(8'h00, r2);
    cs_hi();
    chk("rd_reg14", {24'd0, r1}, {24'd0, exp_11});
    chk("rd_reg15", {24'd0, r2}, {24'd0, exp_22});
    chk("rd_no_wr", wr_cnt, wr0);
    chk("rd_reg3_kept", {24'd0, dut.regs[3]}, 32'hA5);

    wr0 = wr_cnt;
    fe0 = ferr_cnt;
    cs_lo();
    xfer(8'h05, rx);
    xbit(1'b1, rb); xbit(1'b0, rb); xbit(1'b1, rb); xbit(1'b0, rb);
    cs_hi();
    chk("ferr_pulse", ferr_cnt - fe0, 1);
    chk("ferr_no_wr", wr_cnt, wr0);
    chk("ferr_reg5", {24'd0, dut.regs[5]}, 0);
    chk("ferr_busy", {31'd0, busy}, 0);

    fe0 = ferr_cnt;
    cs_lo();
    xfer(8'h04, rx);
    cs_hi();
    chk("silent_abort_ferr", ferr_cnt, fe0);
    chk("silent_abort_busy", {31'd0, busy}, 0);

    wr0 = wr_cnt;
    fe0 = ferr_cnt;
    cs_lo();
    xfer(8'h02, rx);
    xbit(1'b0, rb); xbit(1'b1, rb); xbit(1'b1, rb);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #20;
    chk("rst_mid_busy", {31'd0, busy}, 0);
    xfer(8'h02, rx);
    xfer(8'h7F, rx);
    chk("rst_ignore_busy", {31'd0, busy}, 0);
    cs_hi();
    chk("rst_mid_no_wr", wr_cnt, wr0);
    chk("rst_mid_no_ferr", ferr_cnt, fe0);
    chk("rst_mid_reg2", {24'd0, dut.regs[2]}, 0);
    chk("rst_cleared_reg3", {24'd0, dut.regs[3]}, 0);

    sb.push_back({4'd2, 8'h7F});
    cs_lo();
    xfer(8'h02, rx);
    xfer(8'h7F, rx);
    cs_hi();
    chk("post_rst_pending", sb.size(), 0);
    chk("post_rst_reg2", {24'd0, dut.regs[2]}, 32'h7F);
    chk("post_rst_wr_cnt", wr_cnt, wr0 + 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
